run_ctrl: RTL and testbench

Stopwatch run controller for the scoreboard display. It takes the operator's start/stop, clear and lap buttons, debounces them, and sequences the digit counter through a small state machine. It drives the counter's count-enable and clear strobes. It also holds a frame-aligned copy of the digits that feeds the digit mux, so the displayed value changes only at frame boundaries and can be frozen for a lap.

---
 rtl/run_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_run_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Stopwatch run controller: debounced buttons, run/pause/lap FSM and a frame-aligned digit latch.
// Define LAP_EN to build the lap debouncer, the LAP state and the lap display freeze.

module run_ctrl_debounce #(
  parameter int DEBOUNCE = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          prev_q;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = level_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

module run_ctrl #(
  parameter int DEBOUNCE = 250000
) (
  input  logic       clk_ctl,
  input  logic       rst_ctl,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  input  logic       frame_start,
  input  logic [3:0] sec_digit_in,
  input  logic [2:0] dec_digit_in,
  input  logic [3:0] min_digit_in,
  output logic       tick_en,
  output logic       clr_out,
  output logic [3:0] sec_digit_out,
  output logic [2:0] dec_digit_out,
  output logic [3:0] min_digit_out,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       tick_q;
  logic       tick_d;
  logic       clr_q;
  logic       clr_d;
  logic [3:0] sec_q;
  logic [3:0] sec_d;
  logic [2:0] dec_q;
  logic [2:0] dec_d;
  logic [3:0] min_q;
  logic [3:0] min_d;

  logic ss_ev;
  logic clr_ev;
  logic lap_ev;
  logic freeze;

  run_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ss (
    .clk     (clk_ctl),
    .rst     (rst_ctl),
    .btn_raw (btn_ss),
    .press   (ss_ev)
  );

  run_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_clr (
    .clk     (clk_ctl),
    .rst     (rst_ctl),
    .btn_raw (btn_clr),
    .press   (clr_ev)
  );

`ifdef LAP_EN
  run_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_lap (
    .clk     (clk_ctl),
    .rst     (rst_ctl),
    .btn_raw (btn_lap),
    .press   (lap_ev)
  );

  assign freeze = (state_q == LAP);
`else
  logic unused_lap;

  assign unused_lap = btn_lap;
  assign lap_ev     = 1'b0;
  assign freeze     = 1'b0;
`endif

  // Only the highest-priority event is considered; an ignored clear still swallows the others.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (clr_ev) begin
      case (state_q)
        IDLE:    clr_d = 1'b1;
        PAUSE: begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end else if (ss_ev) begin
      case (state_q)
        IDLE, PAUSE: state_d = RUN;
        RUN, LAP:    state_d = PAUSE;
        default:     ;
      endcase
    end else if (lap_ev) begin
      case (state_q)
        RUN:     state_d = LAP;
        LAP:     state_d = RUN;
        default: ;
      endcase
    end
    tick_d = (state_d == RUN) || (state_d == LAP);
  end

  // A clear zeroes the display immediately; otherwise it only changes on a frame boundary.
  always_comb begin
    sec_d = sec_q;
    dec_d = dec_q;
    min_d = min_q;
    if (clr_d) begin
      sec_d = '0;
      dec_d = '0;
      min_d = '0;
    end else if (frame_start && !freeze) begin
      sec_d = sec_digit_in;
      dec_d = dec_digit_in;
      min_d = min_digit_in;
    end
  end

  always_ff @(posedge clk_ctl) begin
    if (rst_ctl) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      sec_q   <= '0;
      dec_q   <= '0;
      min_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      sec_q   <= sec_d;
      dec_q   <= dec_d;
      min_q   <= min_d;
    end
  end

  assign tick_en       = tick_q;
  assign clr_out       = clr_q;
  assign sec_digit_out = sec_q;
  assign dec_digit_out = dec_q;
  assign min_digit_out = min_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl with DEBOUNCE=4; covers the LAP_EN build or the default build.

module tb_run_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  localparam logic [2:0] B_SS  = 3'b001;
  localparam logic [2:0] B_CLR = 3'b010;
  localparam logic [2:0] B_LAP = 3'b100;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       tick;
    logic       clr;
    logic [3:0] sec;
    logic [2:0] dec;
    logic [3:0] mn;
    string      name;
  } exp_t;

  logic       clk_ctl = 1'b0;
  logic       rst_ctl;
  logic       btn_ss;
  logic       btn_clr;
  logic       btn_lap;
  logic       frame_start;
  logic [3:0] sec_digit_in;
  logic [2:0] dec_digit_in;
  logic [3:0] min_digit_in;
  logic       tick_en;
  logic       clr_out;
  logic [3:0] sec_digit_out;
  logic [2:0] dec_digit_out;
  logic [3:0] min_digit_out;
  logic [1:0] state_out;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_total = 0;
  int         n_pass = 0;
  logic [1:0] exp_state;
  logic [3:0] exp_sec;
  logic [2:0] exp_dec;
  logic [3:0] exp_min;

  run_ctrl #(.DEBOUNCE(4)) dut (
    .clk_ctl       (clk_ctl),
    .rst_ctl       (rst_ctl),
    .btn_ss        (btn_ss),
    .btn_clr       (btn_clr),
    .btn_lap       (btn_lap),
    .frame_start   (frame_start),
    .sec_digit_in  (sec_digit_in),
    .dec_digit_in  (dec_digit_in),
    .min_digit_in  (min_digit_in),
    .tick_en       (tick_en),
    .clr_out       (clr_out),
    .sec_digit_out (sec_digit_out),
    .dec_digit_out (dec_digit_out),
    .min_digit_out (min_digit_out),
    .state_out     (state_out)
  );

  always #5 clk_ctl = ~clk_ctl;

  always @(posedge clk_ctl) cyc <= cyc + 1;

  // Monitor: compares each queued expectation on the falling edge of its target cycle.
  always @(negedge clk_ctl) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_total++;
      if (e.cyc != cyc) begin
        $display("[TB] FAIL %s: expectation for cycle %0d not compared (now cycle %0d)", e.name, e.cyc, cyc);
      end else if (state_out === e.st && tick_en === e.tick && clr_out === e.clr &&
                   sec_digit_out === e.sec && dec_digit_out === e.dec && min_digit_out === e.mn) begin
        n_pass++;
      end else begin
        $display("[TB] FAIL %s @cycle %0d: got st=%b tick=%b clr=%b dig=%0d/%0d/%0d, want st=%b tick=%b clr=%b dig=%0d/%0d/%0d",
                 e.name, cyc, state_out, tick_en, clr_out, min_digit_out, dec_digit_out, sec_digit_out,
                 e.st, e.tick, e.clr, e.mn, e.dec, e.sec);
      end
    end
  end

  // Queue an expected snapshot for 'delay' cycles after the current one.
  task automatic checkOutput(input string name, input int delay, input logic [1:0] st, input logic clr);
    exp_t e;
    e.cyc  = cyc + delay;
    e.st   = st;
    e.tick = (st == S_RUN) || (st == S_LAP);
    e.clr  = clr;
    e.sec  = clr ? 4'd0 : exp_sec;
    e.dec  = clr ? 3'd0 : exp_dec;
    e.mn   = clr ? 4'd0 : exp_min;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk_ctl);
    #1;
  endtask

  // Press the buttons in 'mask' long enough for one event; the FSM moves 8 cycles after the drive.
  task automatic applyStimulus(input logic [2:0] mask, input logic [1:0] pre, input logic [1:0] post,
                               input logic clr, input string name);
    btn_ss  = mask[0];
    btn_clr = mask[1];
    btn_lap = mask[2];
    checkOutput({name, "_pre"}, 7, pre, 1'b0);
    checkOutput(name, 8, post, clr);
    if (clr) begin
      exp_sec = 4'd0;
      exp_dec = 3'd0;
      exp_min = 4'd0;
    end
    checkOutput({name, "_after"}, 9, post, 1'b0);
    exp_state = post;
    stepCycles(8);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    btn_lap = 1'b0;
    stepCycles(12);
  endtask

  task automatic doFrame(input logic [3:0] s, input logic [2:0] d, input logic [3:0] m,
                         input logic loads, input string name);
    sec_digit_in = s;
    dec_digit_in = d;
    min_digit_in = m;
    frame_start  = 1'b1;
    stepCycles(1);
    frame_start  = 1'b0;
    if (loads) begin
      exp_sec = s;
      exp_dec = d;
      exp_min = m;
    end
    checkOutput(name, 0, exp_state, 1'b0);
    stepCycles(3);
  endtask

  initial begin
    rst_ctl      = 1'b1;
    btn_ss       = 1'b0;
    btn_clr      = 1'b0;
    btn_lap      = 1'b0;
    frame_start  = 1'b0;
    sec_digit_in = 4'd5;
    dec_digit_in = 3'd2;
    min_digit_in = 4'd7;
    exp_state    = S_IDLE;
    exp_sec      = 4'd0;
    exp_dec      = 3'd0;
    exp_min      = 4'd0;

    stepCycles(3);
    checkOutput("reset", 0, S_IDLE, 1'b0);
    rst_ctl = 1'b0;

    while (cyc < 9) stepCycles(1);
    btn_ss = 1'b1;
    checkOutput("start_pre", 7, S_IDLE, 1'b0);
    checkOutput("start", 8, S_RUN, 1'b0);
    exp_state = S_RUN;
    while (cyc < 20) stepCycles(1);
    btn_ss = 1'b0;
    stepCycles(12);
    checkOutput("release_no_event", 0, S_RUN, 1'b0);

    btn_ss = 1'b1;
    stepCycles(3);
    btn_ss = 1'b0;
    stepCycles(12);
    checkOutput("chatter", 0, S_RUN, 1'b0);

    doFrame(4'd5, 3'd2, 4'd7, 1'b1, "frame_run");
    applyStimulus(B_SS, S_RUN, S_PAUSE, 1'b0, "pause");
    doFrame(4'd6, 3'd2, 4'd7, 1'b1, "frame_pause");
    applyStimulus(B_CLR, S_PAUSE, S_IDLE, 1'b1, "clear");
    applyStimulus(B_SS, S_IDLE, S_RUN, 1'b0, "restart");
    doFrame(4'd3, 3'd1, 4'd2, 1'b1, "frame_run2");

`ifdef LAP_EN
    applyStimulus(B_LAP, S_RUN, S_LAP, 1'b0, "lap_enter");
    for (int i = 0; i < 3; i++) doFrame(4'(4 + i), 3'd1, 4'd2, 1'b0, "lap_hold");
    applyStimulus(B_LAP, S_LAP, S_RUN, 1'b0, "lap_exit");
    doFrame(4'd7, 3'd1, 4'd2, 1'b1, "lap_update");
`else
    applyStimulus(B_LAP, S_RUN, S_RUN, 1'b0, "lap_ignored");
    for (int i = 0; i < 3; i++) doFrame(4'(4 + i), 3'd1, 4'd2, 1'b1, "nolap_frame");
`endif

    applyStimulus(B_CLR, S_RUN, S_RUN, 1'b0, "clear_ignored_run");
    applyStimulus(B_SS, S_RUN, S_PAUSE, 1'b0, "pause2");
    applyStimulus(B_CLR | B_SS, S_PAUSE, S_IDLE, 1'b1, "simultaneous");
    checkOutput("no_run", 5, S_IDLE, 1'b0);
    stepCycles(6);

    doFrame(4'd9, 3'd5, 4'd9, 1'b1, "frame_idle");
    rst_ctl = 1'b1;
    btn_ss  = 1'b1;
    stepCycles(2);
    exp_state = S_IDLE;
    exp_sec   = 4'd0;
    exp_dec   = 3'd0;
    exp_min   = 4'd0;
    checkOutput("reset_mid", 0, S_IDLE, 1'b0);
    rst_ctl = 1'b0;
    checkOutput("held_pre", 7, S_IDLE, 1'b0);
    checkOutput("held_event", 8, S_RUN, 1'b0);
    exp_state = S_RUN;
    stepCycles(12);
    btn_ss = 1'b0;
    stepCycles(12);
    checkOutput("held_single", 0, S_RUN, 1'b0);

    stepCycles(3);
    while (sb.size() > 0) begin
      n_total++;
      $display("[TB] FAIL %s: expectation for cycle %0d never compared (now cycle %0d)", sb[0].name, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    n_total++;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
